// File: rtl/adc_frame_packer.sv
// Packs the aligned ADC sample stream into fixed-length frames: header, payload, trailer.
// A mid-frame alignment loss pads the frame to full length and flags it as truncated.
module adc_frame_packer #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       FRAME_LEN = 256,
  parameter logic [DATA_W-1:0] PAD_WORD  = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              aligned,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [31:0]       frame_count,
  output logic [15:0]       trunc_count
);

  localparam logic [14:0] FrameLen = 15'(FRAME_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPayload,
    StPad,
    StTrailer
  } state_e;

  state_e            state_q, state_d;
  logic [11:0]       seq_q, seq_d;
  logic [14:0]       wcnt_q, wcnt_d;
  logic [14:0]       vcnt_q, vcnt_d;
  logic              trunc_q, trunc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [31:0]       fcnt_q, fcnt_d;
  logic [15:0]       tcnt_q, tcnt_d;

  logic              adv;
  logic              accept;
  logic [14:0]       wcnt_inc;
  logic [DATA_W-1:0] hdr_word;
  logic [DATA_W-1:0] trl_word;

  // The output register may load whenever it is empty or being drained this cycle.
  assign adv      = !valid_q || m_ready;
  assign s_ready  = (state_q == StPayload) && aligned && adv;
  assign accept   = s_valid && s_ready;
  assign wcnt_inc = wcnt_q + 15'd1;

  always_comb begin
    hdr_word        = '0;
    hdr_word[15:0]  = {4'hA, seq_q};
    trl_word        = '0;
    trl_word[15:0]  = {trunc_q, vcnt_q};
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    wcnt_d  = wcnt_q;
    vcnt_d  = vcnt_q;
    trunc_d = trunc_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    fcnt_d  = fcnt_q;
    tcnt_d  = tcnt_q;

    // Drained with nothing new to load: drop valid, data is left as is.
    if (adv) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (aligned && s_valid) state_d = StHdr;
      end
      StHdr: begin
        if (adv) begin
          data_d  = hdr_word;
          valid_d = 1'b1;
          wcnt_d  = '0;
          vcnt_d  = '0;
          state_d = StPayload;
        end
      end
      StPayload: begin
        if (accept) begin
          data_d  = s_data;
          valid_d = 1'b1;
          wcnt_d  = wcnt_inc;
          vcnt_d  = vcnt_q + 15'd1;
          if (wcnt_inc == FrameLen) state_d = StTrailer;
        end else if (!aligned) begin
          // accept implies aligned, so the last word can never be lost to this branch.
          trunc_d = 1'b1;
          state_d = StPad;
        end
      end
      StPad: begin
        if (adv) begin
          data_d  = PAD_WORD;
          valid_d = 1'b1;
          wcnt_d  = wcnt_inc;
          if (wcnt_inc == FrameLen) state_d = StTrailer;
        end
      end
      StTrailer: begin
        if (adv) begin
          data_d  = trl_word;
          valid_d = 1'b1;
          last_d  = 1'b1;
          seq_d   = seq_q + 12'd1;
          fcnt_d  = fcnt_q + 32'd1;
          if (trunc_q && (tcnt_q != 16'hFFFF)) tcnt_d = tcnt_q + 16'd1;
          trunc_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      seq_q   <= '0;
      wcnt_q  <= '0;
      vcnt_q  <= '0;
      trunc_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      wcnt_q  <= wcnt_d;
      vcnt_q  <= vcnt_d;
      trunc_q <= trunc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign m_data      = data_q;
  assign m_valid     = valid_q;
  assign m_last      = last_q;
  assign frame_count = fcnt_q;
  assign trunc_count = tcnt_q;

endmodule
